// File: rtl/adc_sample_buffer_if.sv
// ---------------------------------------------------------------------------
// adc_sample_buffer_if
// Streaming handshake bundle for the ADC sample buffer.
//   adc_data_in / adc_valid_in / adc_ready_out : ADC -> buffer sample stream
//   sample_out / sample_valid_out / sample_ready_in : buffer -> FIR stream
// The slave modport is the buffer's view; the master modport is the view of
// the surrounding logic (ADC front end plus FIR filter) driving it.
// ---------------------------------------------------------------------------
interface adc_sample_buffer_if #(
  parameter int DATA_W = 5
);
  logic [DATA_W-1:0] adc_data_in;
  logic              adc_valid_in;
  logic              adc_ready_out;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid_out;
  logic              sample_ready_in;

  modport master (
    output adc_data_in, adc_valid_in, sample_ready_in,
    input  adc_ready_out, sample_out, sample_valid_out
  );

  modport slave (
    input  adc_data_in, adc_valid_in, sample_ready_in,
    output adc_ready_out, sample_out, sample_valid_out
  );
endinterface

// File: rtl/adc_sample_buffer.sv
// ---------------------------------------------------------------------------
// adc_sample_buffer
// Decimating first-word-fall-through FIFO between an ADC and a FIR filter.
// Every ADC transfer advances a decimation counter; only transfers seen with
// the counter at 0 are stored, so factor N keeps one sample in N.
// Ports:
//   clk, resetn    : clock (rising edge) and asynchronous active-low reset
//   bus            : ADC input stream and FIR output stream (slave modport)
//   decim_sel      : decimation factor select, 0->1, 1->2, 2->4, 3->8
//   fill_level     : FIFO occupancy, 0..DEPTH
//   overflow_out   : sticky, set when an offered ADC sample was refused
//   clear_ovf_in   : synchronous clear of overflow_out (a new loss wins)
// ---------------------------------------------------------------------------
module adc_sample_buffer #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 4   // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  adc_sample_buffer_if.slave       bus,
  input  logic [1:0]               decim_sel,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow_out,
  input  logic                     clear_ovf_in
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [2:0]        dcnt_q, dcnt_d;
  logic [2:0]        dcnt_eff;   // counter value seen by this cycle's transfer
  logic [2:0]        dcnt_max;   // factor - 1
  logic [1:0]        decim_sel_q;
  logic              ovf_q, ovf_d;

  logic sel_change, keep, full, empty;
  logic xfer, push, pop, lost;

  // -------------------------------------------------------------------------
  // Handshake and decimation decode
  // -------------------------------------------------------------------------
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // A new factor restarts the count in the very cycle it appears, so the
  // first transfer under the new factor is always kept.
  assign sel_change = (decim_sel != decim_sel_q);
  assign dcnt_eff   = sel_change ? 3'd0 : dcnt_q;
  assign keep       = (dcnt_eff == 3'd0);

  // Samples that will be discarded need no FIFO space, so they are accepted
  // even when the FIFO is full.
  assign bus.adc_ready_out = !full || !keep;

  assign xfer = bus.adc_valid_in && bus.adc_ready_out;
  assign push = xfer && keep;
  assign pop  = !empty && bus.sample_ready_in;
  assign lost = bus.adc_valid_in && !bus.adc_ready_out;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    dcnt_max = 3'd0;
    dcnt_d   = dcnt_eff;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    unique case (decim_sel)
      2'd0: dcnt_max = 3'd0;
      2'd1: dcnt_max = 3'd1;
      2'd2: dcnt_max = 3'd3;
      2'd3: dcnt_max = 3'd7;
    endcase

    if (xfer) begin
      dcnt_d = (dcnt_eff == dcnt_max) ? 3'd0 : dcnt_eff + 3'd1;
    end

    // Pointers are PTR_W bits and DEPTH is a power of two, so the increment
    // wraps DEPTH-1 -> 0 naturally.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Set has priority over clear so a loss in the clearing cycle is kept.
    if (lost)              ovf_d = 1'b1;
    else if (clear_ovf_in) ovf_d = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      dcnt_q      <= '0;
      decim_sel_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      dcnt_q      <= dcnt_d;
      decim_sel_q <= decim_sel;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by level_q and
  // the output is gated while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.adc_data_in;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.sample_valid_out = !empty;
  assign bus.sample_out       = empty ? '0 : mem_q[rd_ptr_q];
  assign fill_level           = level_q;
  assign overflow_out         = ovf_q;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// ---------------------------------------------------------------------------
// tb_adc_sample_buffer
// Directed bench for adc_sample_buffer (DATA_W=5, DEPTH=4). Inputs change
// 1 ns after each rising edge; outputs are compared at that point, away from
// the edge. Tests run in sequence and share one running pointer/counter
// history, which the expected values below account for.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_sample_buffer;

  localparam int DATA_W = 5;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] decim_sel;
  logic [2:0] fill_level;
  logic       overflow_out;
  logic       clear_ovf_in;

  int checks = 0;
  int errors = 0;

  adc_sample_buffer_if #(.DATA_W(DATA_W)) bus ();

  adc_sample_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus.slave),
    .decim_sel    (decim_sel),
    .fill_level   (fill_level),
    .overflow_out (overflow_out),
    .clear_ovf_in (clear_ovf_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn           = 1'b0;
    decim_sel        = 2'd0;
    clear_ovf_in     = 1'b0;
    bus.adc_data_in  = '0;
    bus.adc_valid_in = 1'b0;
    bus.sample_ready_in = 1'b0;
    #3;
    checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
    checks++; if (bus.sample_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.sample_valid_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow_out); end
    checks++; if (bus.sample_out !== 5'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", bus.sample_out); end
    tick();
    tick();
    resetn = 1'b1;
    tick();
    checks++; if (bus.adc_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.adc_ready_out); end
  endtask

  // decim_sel=0, samples 1,2,3 back to back, FIR always ready.
  task automatic test_passthrough();
    bus.sample_ready_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.adc_valid_in = 1'b1;
      bus.adc_data_in  = 5'(i);
      tick();
      checks++; if (bus.sample_valid_out !== 1'b1 || bus.sample_out !== 5'(i))
        begin errors++; $display("FAIL pass_data%0d got v=%b d=%0d exp v=1 d=%0d", i, bus.sample_valid_out, bus.sample_out, i); end
      checks++; if (fill_level !== 3'd1) begin errors++; $display("FAIL pass_fill%0d got %0d exp 1", i, fill_level); end
    end
    bus.adc_valid_in = 1'b0;
    tick();
    checks++; if (bus.sample_valid_out !== 1'b0 || fill_level !== 3'd0)
      begin errors++; $display("FAIL pass_drain got v=%b fill=%0d exp v=0 fill=0", bus.sample_valid_out, fill_level); end
  endtask

  // decim_sel=2 (factor 4), samples 0..11: only 0, 4, 8 come out.
  task automatic test_decim4();
    int emitted;
    emitted = 0;
    decim_sel = 2'd2;
    tick();                        // idle cycle lets the new factor settle
    bus.sample_ready_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.adc_valid_in = 1'b1;
      bus.adc_data_in  = 5'(i);
      #1;
      checks++; if (bus.adc_ready_out !== 1'b1) begin errors++; $display("FAIL dec4_ready%0d got %b exp 1", i, bus.adc_ready_out); end
      tick();
      if (i % 4 == 0) begin
        checks++; if (bus.sample_valid_out !== 1'b1 || bus.sample_out !== 5'(i))
          begin errors++; $display("FAIL dec4_keep%0d got v=%b d=%0d exp v=1 d=%0d", i, bus.sample_valid_out, bus.sample_out, i); end
        if (bus.sample_valid_out === 1'b1) emitted++;
      end else begin
        checks++; if (bus.sample_valid_out !== 1'b0)
          begin errors++; $display("FAIL dec4_drop%0d got v=%b d=%0d exp v=0", i, bus.sample_valid_out, bus.sample_out); end
      end
    end
    bus.adc_valid_in = 1'b0;
    tick();
    checks++; if (emitted !== 3) begin errors++; $display("FAIL dec4_count got %0d exp 3", emitted); end
  endtask

  // FIR stalled: 5 kept samples into a 4-deep FIFO.
  task automatic test_overflow();
    decim_sel = 2'd0;
    tick();
    bus.sample_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.adc_valid_in = 1'b1;
      bus.adc_data_in  = 5'(10 + i);
      #1;
      checks++; if (bus.adc_ready_out !== (i < 4))
        begin errors++; $display("FAIL ovf_ready%0d got %b exp %b", i, bus.adc_ready_out, (i < 4)); end
      tick();
    end
    bus.adc_valid_in = 1'b0;
    checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL ovf_fill got %0d exp 4", fill_level); end
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow_out); end
    tick();
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow_out); end
    clear_ovf_in = 1'b1;
    tick();
    clear_ovf_in = 1'b0;
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow_out); end
    bus.sample_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.sample_valid_out !== 1'b1 || bus.sample_out !== 5'(10 + i))
        begin errors++; $display("FAIL ovf_drain%0d got v=%b d=%0d exp v=1 d=%0d", i, bus.sample_valid_out, bus.sample_out, 10 + i); end
      tick();
    end
    checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL ovf_empty got %0d exp 0", fill_level); end
  endtask

  // Fill to 2, then 4 cycles of simultaneous push+pop. 10 pushes so far put
  // both pointers at 2, so this pass wraps them past DEPTH-1.
  task automatic test_push_pop();
    bus.sample_ready_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.adc_valid_in = 1'b1;
      bus.adc_data_in  = 5'(20 + i);
      tick();
    end
    checks++; if (fill_level !== 3'd2) begin errors++; $display("FAIL pp_prefill got %0d exp 2", fill_level); end
    bus.sample_ready_in = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.adc_data_in = 5'(22 + j);
      checks++; if (bus.sample_out !== 5'(20 + j))
        begin errors++; $display("FAIL pp_head%0d got %0d exp %0d", j, bus.sample_out, 20 + j); end
      tick();
      checks++; if (fill_level !== 3'd2) begin errors++; $display("FAIL pp_fill%0d got %0d exp 2", j, fill_level); end
    end
    bus.adc_valid_in = 1'b0;
    for (int j = 0; j < 2; j++) begin
      checks++; if (bus.sample_out !== 5'(24 + j))
        begin errors++; $display("FAIL pp_tail%0d got %0d exp %0d", j, bus.sample_out, 24 + j); end
      tick();
    end
    checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL pp_empty got %0d exp 0", fill_level); end
  endtask

  // Factor 8 mid-count (3 transfers in), then switch to factor 2 on the
  // same cycle as the next transfer.
  task automatic test_decim_change();
    logic [4:0] vals [8] = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    logic [1:0] sels [8] = '{2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    logic       kept [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    decim_sel = 2'd3;
    tick();
    bus.sample_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      decim_sel        = sels[i];
      bus.adc_valid_in = 1'b1;
      bus.adc_data_in  = vals[i];
      tick();
      checks++; if (bus.sample_valid_out !== kept[i] || (kept[i] && bus.sample_out !== vals[i]))
        begin errors++; $display("FAIL dchg%0d got v=%b d=%0d exp v=%b d=%0d", i, bus.sample_valid_out, bus.sample_out, kept[i], vals[i]); end
    end
    bus.adc_valid_in = 1'b0;
    tick();
  endtask

  // Asynchronous reset with 3 entries buffered.
  task automatic test_reset_mid();
    decim_sel = 2'd0;
    tick();
    bus.sample_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.adc_valid_in = 1'b1;
      bus.adc_data_in  = 5'(7 + i);
      tick();
    end
    bus.adc_valid_in = 1'b0;
    checks++; if (fill_level !== 3'd3) begin errors++; $display("FAIL rmid_pre got %0d exp 3", fill_level); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (bus.sample_valid_out !== 1'b0 || fill_level !== 3'd0)
      begin errors++; $display("FAIL rmid_async got v=%b fill=%0d exp v=0 fill=0", bus.sample_valid_out, fill_level); end
    checks++; if (bus.sample_out !== 5'd0) begin errors++; $display("FAIL rmid_data got %0d exp 0", bus.sample_out); end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    bus.adc_valid_in = 1'b1;
    bus.adc_data_in  = 5'd17;
    tick();
    bus.adc_valid_in = 1'b0;
    checks++; if (bus.sample_valid_out !== 1'b1 || bus.sample_out !== 5'd17 || fill_level !== 3'd1)
      begin errors++; $display("FAIL rmid_first got v=%b d=%0d fill=%0d exp v=1 d=17 fill=1", bus.sample_valid_out, bus.sample_out, fill_level); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_decim4();
    test_overflow();
    test_push_pop();
    test_decim_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
